// File: rtl/board_pkg.sv
// Shared constants, state/region encodings and layout-index helpers for the
// board deal controller.
package board_pkg;
  localparam int TILE_W       = 4;
  localparam int EDGE_TILES   = 24;
  localparam int CENTER_TILES = 12;
  localparam int TILE_MAX     = 11;
  localparam int NUM_LAYOUTS  = 10;
  localparam int GEN_LAT      = 1;
  localparam int ADDR_W       = 5;
  localparam int SEL_W        = 4;

  localparam logic REGION_EDGE   = 1'b0;
  localparam logic REGION_CENTER = 1'b1;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // bits 7,5,4,3

  typedef enum logic [2:0] {IDLE, SELECT, LATCH, EDGE, CENTER, DONE} state_e;

  // Element 0 is the MSB nibble, matching the generator's packing.
  typedef logic [0:EDGE_TILES-1][TILE_W-1:0]   edge_vec_t;
  typedef logic [0:CENTER_TILES-1][TILE_W-1:0] center_vec_t;

  function automatic logic [SEL_W-1:0] lfsr_to_layout(input logic [7:0] v);
    return SEL_W'(v % 8'(NUM_LAYOUTS));
  endfunction

  // Debug index only ever exceeds the table by less than one wrap.
  function automatic logic [SEL_W-1:0] clamp_force(input logic [SEL_W-1:0] f);
    return (f >= SEL_W'(NUM_LAYOUTS)) ? f - SEL_W'(NUM_LAYOUTS) : f;
  endfunction
endpackage

// File: rtl/board_setup_ctrl_if.sv
// Tile-write handshake toward the board tile memory.
interface board_setup_ctrl_if;
  import board_pkg::*;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_region;
  logic [ADDR_W-1:0] wr_addr;
  logic [TILE_W-1:0] wr_tile;

  modport master (output wr_valid, wr_region, wr_addr, wr_tile, input wr_ready);
  modport slave  (input wr_valid, wr_region, wr_addr, wr_tile, output wr_ready);
endinterface

// File: rtl/tile_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick a layout.
module tile_lfsr8
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end
endmodule

// File: rtl/board_setup_ctrl.sv
// Deal sequencer: picks a layout, latches and range-checks the generator's
// tile orders, then streams edge then center tiles into board memory.
module board_setup_ctrl
  import board_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sel_force_en,
  input  logic [SEL_W-1:0]             sel_force,
  input  logic [EDGE_TILES*TILE_W-1:0]   edge_order_in,
  input  logic [CENTER_TILES*TILE_W-1:0] center_order_in,
  output logic [SEL_W-1:0]             layout_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  board_setup_ctrl_if.master           wr
);
  localparam logic [ADDR_W-1:0] EDGE_LAST   = ADDR_W'(EDGE_TILES - 1);
  localparam logic [ADDR_W-1:0] CENTER_LAST = ADDR_W'(CENTER_TILES - 1);
  localparam logic [1:0]        GEN_LAT_M1  = 2'(GEN_LAT - 1);

  logic [7:0]        lfsr;
  state_e            state;
  logic [1:0]        sel_cnt;
  edge_vec_t         edge_in, edge_q;
  center_vec_t       center_in, center_q;
  logic              range_bad;
  logic              wr_valid_q, wr_region_q;
  logic [ADDR_W-1:0] wr_addr_q, nidx;
  logic [TILE_W-1:0] wr_tile_q;

  tile_lfsr8 u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));

  assign edge_in   = edge_order_in;
  assign center_in = center_order_in;
  assign nidx      = wr_addr_q + ADDR_W'(1);

  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < EDGE_TILES; i++)
      if (edge_in[i] > TILE_W'(TILE_MAX)) range_bad = 1'b1;
    for (int i = 0; i < CENTER_TILES; i++)
      if (center_in[i] > TILE_W'(TILE_MAX)) range_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sel_cnt     <= '0;
      layout_sel  <= '0;
      edge_q      <= '0;
      center_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_region_q <= REGION_EDGE;
      wr_addr_q   <= '0;
      wr_tile_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          layout_sel <= sel_force_en ? clamp_force(sel_force) : lfsr_to_layout(lfsr);
          err        <= 1'b0;
          busy       <= 1'b1;
          sel_cnt    <= '0;
          state      <= SELECT;
        end
        SELECT: begin
          sel_cnt <= sel_cnt + 2'd1;
          if (sel_cnt == GEN_LAT_M1) state <= LATCH;
        end
        LATCH: begin
          edge_q   <= edge_in;
          center_q <= center_in;
          if (range_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // First beat is presented straight from the inputs being latched.
            wr_valid_q  <= 1'b1;
            wr_region_q <= REGION_EDGE;
            wr_addr_q   <= '0;
            wr_tile_q   <= edge_in[0];
            state       <= EDGE;
          end
        end
        EDGE: if (wr.wr_ready) begin
          if (wr_addr_q == EDGE_LAST) begin
            wr_region_q <= REGION_CENTER;
            wr_addr_q   <= '0;
            wr_tile_q   <= center_q[0];
            state       <= CENTER;
          end else begin
            wr_addr_q <= nidx;
            wr_tile_q <= edge_q[nidx];
          end
        end
        CENTER: if (wr.wr_ready) begin
          if (wr_addr_q == CENTER_LAST) begin
            wr_valid_q <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            wr_addr_q <= nidx;
            wr_tile_q <= center_q[nidx[3:0]];
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr.wr_valid  = wr_valid_q;
  assign wr.wr_region = wr_region_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_tile   = wr_tile_q;
endmodule

// File: tb/tb_board_setup_ctrl.sv
// Bench for board_setup_ctrl: directed corner sequences, a force-clamp table
// and randomized deals checked against a tile-list reference model.
module tb_board_setup_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel_force_en = 1'b0;
  logic [3:0]  sel_force = '0;
  logic [95:0] edge_v = '0;
  logic [47:0] center_v = '0;
  logic [3:0]  layout_sel;
  logic        busy, done, err;
  logic [7:0]  m_lfsr;

  board_setup_ctrl_if wr();

  board_setup_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sel_force_en(sel_force_en),
    .sel_force(sel_force), .edge_order_in(edge_v), .center_order_in(center_v),
    .layout_sel(layout_sel), .busy(busy), .done(done), .err(err), .wr(wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 8'h01;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  typedef struct packed {logic region; logic [4:0] addr; logic [3:0] tile;} beat_t;
  typedef struct {logic fen; logic [3:0] fsel; logic [3:0] exp_sel;} vec_t;

  int    checks = 0, failures = 0;
  beat_t got[$];
  int    done_cnt, step_no, done_step;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic  stall;
    beat_t cur;
    cur = '{wr.wr_region, wr.wr_addr, wr.wr_tile};
    if (wr.wr_valid && wr.wr_ready) got.push_back(cur);
    stall = wr.wr_valid && !wr.wr_ready;
    @(posedge clk); #1;
    step_no++;
    if (done) begin
      done_cnt++;
      if (done_step < 0) done_step = step_no;
    end
    if (stall) chk("hold", {wr.wr_valid, wr.wr_region, wr.wr_addr, wr.wr_tile}, {1'b1, cur});
  endtask

  task automatic set_edge(input int i, input logic [3:0] t);
    edge_v[4*(24-i)-1 -: 4] = t;
  endtask
  task automatic set_center(input int i, input logic [3:0] t);
    center_v[4*(12-i)-1 -: 4] = t;
  endtask
  task automatic identity();
    for (int i = 0; i < 24; i++) set_edge(i, 4'(i % 12));
    for (int i = 0; i < 12; i++) set_center(i, 4'(i));
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall 3 cycles at edge 5 and edge 23
  task automatic run_deal(input logic fen, input logic [3:0] fsel, input int ready_mode,
                          input int pulse_beat, input int abort_beat, input logic scramble,
                          input string tag, output logic [3:0] sel_seen);
    beat_t      exp[$];
    logic [3:0] exp_sel, t;
    logic       exp_err, pulsed, aborted;
    int         hold, mism;
    exp_sel = fen ? 4'(fsel % 10) : 4'(m_lfsr % 10);
    exp_err = 1'b0;
    for (int i = 0; i < 24; i++) begin
      t = edge_v[4*(24-i)-1 -: 4];
      if (t > 11) exp_err = 1'b1;
      exp.push_back('{1'b0, 5'(i), t});
    end
    for (int i = 0; i < 12; i++) begin
      t = center_v[4*(12-i)-1 -: 4];
      if (t > 11) exp_err = 1'b1;
      exp.push_back('{1'b1, 5'(i), t});
    end
    got.delete(); done_cnt = 0; step_no = 0; done_step = -1;
    pulsed = 0; aborted = 0; hold = 0;
    sel_force_en = fen; sel_force = fsel; start = 1'b1; wr.wr_ready = 1'b1;
    step();
    start = 1'b0;
    sel_seen = layout_sel;
    chk({tag, " layout"}, layout_sel, exp_sel);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " err_clr"}, err, 0);
    for (int c = 0; c < 300 && busy; c++) begin
      start = 1'b0;
      case (ready_mode)
        0: wr.wr_ready = 1'b1;
        1: wr.wr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (wr.wr_valid && !wr.wr_region && (wr.wr_addr == 5 || wr.wr_addr == 23) && hold < 3) begin
            if (hold > 0 && wr.wr_addr == 5) chk({tag, " stall_tile"}, wr.wr_tile, 5);
            wr.wr_ready = 1'b0; hold++;
          end else begin
            wr.wr_ready = 1'b1; hold = 0;
          end
        end
      endcase
      if (scramble && step_no == 3) begin
        edge_v = {$urandom, $urandom, $urandom};
        center_v = {$urandom, $urandom};
      end
      if (pulse_beat >= 0 && !pulsed && wr.wr_valid && !wr.wr_region && got.size() == pulse_beat) begin
        start = 1'b1; sel_force_en = 1'b1; sel_force = 4'd7; pulsed = 1;
      end
      if (abort_beat >= 0 && wr.wr_valid && wr.wr_region && got.size() == 24 + abort_beat) begin
        #2 rst = 1'b0;
        #1;
        chk({tag, " abort_valid"}, wr.wr_valid, 0);
        chk({tag, " abort_busy"}, busy, 0);
        aborted = 1;
        break;
      end
      step();
    end
    start = 1'b0;
    if (aborted) begin
      chk({tag, " abort_done"}, done_cnt + done, 0);
      @(negedge clk); rst = 1'b1;
      return;
    end
    chk({tag, " finish"}, busy, 0);
    if (exp_err) begin
      chk({tag, " err"}, err, 1);
      chk({tag, " nbeats"}, got.size(), 0);
      chk({tag, " ndone"}, done_cnt, 0);
    end else begin
      chk({tag, " err"}, err, 0);
      chk({tag, " ndone"}, done_cnt, 1);
      chk({tag, " nbeats"}, got.size(), 36);
      mism = 0;
      if (got.size() == 36)
        for (int i = 0; i < 36; i++) if (got[i] !== exp[i]) mism++;
      chk({tag, " beats"}, mism, 0);
      chk({tag, " sel_hold"}, layout_sel, exp_sel);
      if (ready_mode == 0) chk({tag, " done_t39"}, done_step, 39);
    end
  endtask

  initial begin
    vec_t       tbl[6];
    logic [3:0] s;
    int         k;
    tbl[0] = '{1'b1, 4'd12, 4'd2};
    tbl[1] = '{1'b1, 4'd15, 4'd5};
    tbl[2] = '{1'b1, 4'd10, 4'd0};
    tbl[3] = '{1'b1, 4'd9,  4'd9};
    tbl[4] = '{1'b1, 4'd0,  4'd0};
    tbl[5] = '{1'b1, 4'd11, 4'd1};
    wr.wr_ready = 1'b0;
    identity();
    #3;
    chk("rst layout", layout_sel, 0);
    chk("rst flags", {busy, done, err, wr.wr_valid}, 0);
    chk("rst wr", {wr.wr_region, wr.wr_addr, wr.wr_tile}, 0);

    @(negedge clk); rst = 1'b1;
    run_deal(1'b0, 4'd0, 0, -1, -1, 1'b0, "seed", s);
    chk("seed sel", s, 1);

    run_deal(1'b1, 4'd2, 0, -1, -1, 1'b0, "ident", s);
    chk("ident sel", s, 2);

    run_deal(1'b1, 4'd3, 2, -1, -1, 1'b0, "bp", s);

    set_center(7, 4'hC);
    run_deal(1'b1, 4'd3, 0, -1, -1, 1'b0, "rerr", s);
    identity();
    run_deal(1'b0, 4'd0, 1, -1, -1, 1'b0, "clean", s);

    run_deal(1'b1, 4'd4, 0, 10, -1, 1'b0, "busy_start", s);
    for (int i = 0; i < 3; i++) step();
    chk("busy_start idle", {busy, done}, 0);

    run_deal(1'b1, 4'd5, 0, -1, 4, 1'b0, "abort", s);
    run_deal(1'b0, 4'd0, 0, -1, -1, 1'b0, "post_abort", s);

    foreach (tbl[i]) begin
      run_deal(tbl[i].fen, tbl[i].fsel, 1, -1, -1, 1'b0, "tbl", s);
      chk("tbl sel", s, tbl[i].exp_sel);
    end

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 24; i++) set_edge(i, 4'($urandom_range(0, 11)));
      for (int i = 0; i < 12; i++) set_center(i, 4'($urandom_range(0, 11)));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 35);
        if (k < 24) set_edge(k, 4'($urandom_range(12, 15)));
        else        set_center(k - 24, 4'($urandom_range(12, 15)));
      end
      k = $urandom_range(0, 5);
      for (int i = 0; i < k; i++) step();
      run_deal(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1, -1, -1, 1'b1, "rand", s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
